// File: rtl/data_cache_pkg.sv
// Shared constants and FSM encoding for the direct-mapped L1 data cache.
// The widths here describe the default 4-word x 64-set configuration.
package data_cache_pkg;

    localparam int unsigned LINE_WORDS = 4;
    localparam int unsigned SETS       = 64;
    localparam int unsigned OFFSET_W   = $clog2(LINE_WORDS) + 2;
    localparam int unsigned INDEX_W    = $clog2(SETS);
    localparam int unsigned TAG_W      = 32 - INDEX_W - OFFSET_W;

    typedef enum logic [1:0] {
        ST_IDLE        = 2'd0,
        ST_WRITEBACK   = 2'd1,
        ST_REFILL_REQ  = 2'd2,
        ST_REFILL_WAIT = 2'd3
    } state_e;

endpackage

// File: rtl/data_cache_array.sv
// Flop-based line storage: valid/dirty/tag/data per set, one combinational read port
// and one write port that either installs a full line or merges bytes into one word.
module data_cache_array #(
    parameter int unsigned  LINE_WORDS = data_cache_pkg::LINE_WORDS,
    parameter int unsigned  SETS       = data_cache_pkg::SETS,
    localparam int unsigned WORD_BITS  = $clog2(LINE_WORDS),
    localparam int unsigned INDEX_BITS = $clog2(SETS),
    localparam int unsigned TAG_BITS   = 32 - INDEX_BITS - WORD_BITS - 2,
    localparam int unsigned LINE_BITS  = 32 * LINE_WORDS
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [INDEX_BITS-1:0] rd_index,
    output logic                  rd_valid,
    output logic                  rd_dirty,
    output logic [TAG_BITS-1:0]   rd_tag,
    output logic [LINE_BITS-1:0]  rd_line,
    input  logic [INDEX_BITS-1:0] wr_index,
    input  logic                  fill_en,
    input  logic [TAG_BITS-1:0]   fill_tag,
    input  logic [LINE_BITS-1:0]  fill_line,
    input  logic                  word_en,
    input  logic [WORD_BITS-1:0]  word_sel,
    input  logic [31:0]           word_data,
    input  logic [3:0]            word_strb
);
    import data_cache_pkg::*;

    logic [SETS-1:0]      valid_q, valid_d;
    logic [SETS-1:0]      dirty_q, dirty_d;
    logic [TAG_BITS-1:0]  tag_q  [SETS];
    logic [TAG_BITS-1:0]  tag_d  [SETS];
    logic [LINE_BITS-1:0] data_q [SETS];
    logic [LINE_BITS-1:0] data_d [SETS];

    always_comb begin
        valid_d = valid_q;
        dirty_d = dirty_q;
        tag_d   = tag_q;
        data_d  = data_q;
        if (fill_en) begin
            valid_d[wr_index] = 1'b1;
            dirty_d[wr_index] = 1'b0;
            tag_d[wr_index]   = fill_tag;
            data_d[wr_index]  = fill_line;
        end else if (word_en) begin
            dirty_d[wr_index] = 1'b1;
            for (int w = 0; w < int'(LINE_WORDS); w++) begin
                for (int b = 0; b < 4; b++) begin
                    if ((WORD_BITS'(w) == word_sel) && word_strb[b]) begin
                        data_d[wr_index][w*32 + b*8 +: 8] = word_data[b*8 +: 8];
                    end
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= '0;
            dirty_q <= '0;
        end else begin
            valid_q <= valid_d;
            dirty_q <= dirty_d;
        end
    end

    // Tag and data are qualified by valid, so they carry no reset.
    always_ff @(posedge clk) begin
        tag_q  <= tag_d;
        data_q <= data_d;
    end

    assign rd_valid = valid_q[rd_index];
    assign rd_dirty = dirty_q[rd_index];
    assign rd_tag   = tag_q[rd_index];
    assign rd_line  = data_q[rd_index];

endmodule

// File: rtl/data_cache.sv
// Direct-mapped write-back, write-allocate L1 data cache for the MEM stage.
// Hits complete in the request cycle; misses stall through writeback/refill, then replay.
module data_cache #(
    parameter int unsigned  LINE_WORDS = data_cache_pkg::LINE_WORDS,
    parameter int unsigned  SETS       = data_cache_pkg::SETS,
    localparam int unsigned WORD_BITS  = $clog2(LINE_WORDS),
    localparam int unsigned OFF_BITS   = WORD_BITS + 2,
    localparam int unsigned INDEX_BITS = $clog2(SETS),
    localparam int unsigned TAG_BITS   = 32 - INDEX_BITS - OFF_BITS,
    localparam int unsigned LINE_BITS  = 32 * LINE_WORDS
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 req_valid,
    input  logic                 req_we,
    input  logic [31:0]          req_addr,
    input  logic [31:0]          req_wdata,
    input  logic [3:0]           req_wstrb,
    output logic                 data_ok,
    output logic [31:0]          rdata,
    output logic                 stall_from_DCache,
    output logic                 mem_rd_req,
    output logic [31:0]          mem_rd_addr,
    input  logic                 mem_rd_ready,
    input  logic                 mem_rd_valid,
    input  logic [LINE_BITS-1:0] mem_rd_data,
    output logic                 mem_wr_req,
    output logic [31:0]          mem_wr_addr,
    output logic [LINE_BITS-1:0] mem_wr_data,
    input  logic                 mem_wr_ready
);
    import data_cache_pkg::*;

    state_e                state_q, state_d;
    logic [WORD_BITS-1:0]  req_word;
    logic [INDEX_BITS-1:0] req_index;
    logic [TAG_BITS-1:0]   req_tag;
    logic                  vic_valid, vic_dirty;
    logic [TAG_BITS-1:0]   vic_tag;
    logic [LINE_BITS-1:0]  vic_line;
    logic [31:0]           vic_words [LINE_WORDS];
    logic                  hit, lookup, fill_en, word_en;

    assign req_word  = req_addr[2 +: WORD_BITS];
    assign req_index = req_addr[OFF_BITS +: INDEX_BITS];
    assign req_tag   = req_addr[31 -: TAG_BITS];

    data_cache_array #(
        .LINE_WORDS (LINE_WORDS),
        .SETS       (SETS)
    ) u_array (
        .clk       (clk),
        .rst       (rst),
        .rd_index  (req_index),
        .rd_valid  (vic_valid),
        .rd_dirty  (vic_dirty),
        .rd_tag    (vic_tag),
        .rd_line   (vic_line),
        .wr_index  (req_index),
        .fill_en   (fill_en),
        .fill_tag  (req_tag),
        .fill_line (mem_rd_data),
        .word_en   (word_en),
        .word_sel  (req_word),
        .word_data (req_wdata),
        .word_strb (req_wstrb)
    );

    always_comb begin
        for (int w = 0; w < int'(LINE_WORDS); w++) begin
            vic_words[w] = vic_line[w*32 +: 32];
        end
    end

    // Outputs are forced to zero while reset is held so a stale request is never answered.
    always_comb begin
        lookup            = req_valid && !rst && (state_q == ST_IDLE);
        hit               = vic_valid && (vic_tag == req_tag);
        data_ok           = lookup && hit;
        stall_from_DCache = req_valid && !rst && !data_ok;
        rdata             = (data_ok && !req_we) ? vic_words[req_word] : '0;
        mem_wr_req        = !rst && (state_q == ST_WRITEBACK);
        mem_wr_addr       = mem_wr_req ? {vic_tag, req_index, {OFF_BITS{1'b0}}} : '0;
        mem_wr_data       = mem_wr_req ? vic_line : '0;
        mem_rd_req        = !rst && (state_q == ST_REFILL_REQ);
        mem_rd_addr       = mem_rd_req ? {req_tag, req_index, {OFF_BITS{1'b0}}} : '0;
        fill_en           = !rst && (state_q == ST_REFILL_WAIT) && mem_rd_valid;
        word_en           = data_ok && req_we;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: begin
                if (req_valid && !hit) begin
                    state_d = (vic_valid && vic_dirty) ? ST_WRITEBACK : ST_REFILL_REQ;
                end
            end
            ST_WRITEBACK: begin
                if (mem_wr_ready) state_d = ST_REFILL_REQ;
            end
            ST_REFILL_REQ: begin
                if (mem_rd_ready) state_d = ST_REFILL_WAIT;
            end
            ST_REFILL_WAIT: begin
                if (mem_rd_valid) state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

endmodule

// File: tb/tb_data_cache.sv
// Bench for data_cache: directed scenarios then random traffic checked against a flat
// golden memory plus a per-set residency model that predicts memory traffic.
module tb_data_cache;

    logic         clk = 1'b0;
    logic         rst;
    logic         req_valid, req_we;
    logic [31:0]  req_addr, req_wdata;
    logic [3:0]   req_wstrb;
    logic         data_ok, stall_from_DCache;
    logic [31:0]  rdata;
    logic         mem_rd_req, mem_rd_ready, mem_rd_valid;
    logic [31:0]  mem_rd_addr;
    logic [127:0] mem_rd_data;
    logic         mem_wr_req, mem_wr_ready;
    logic [31:0]  mem_wr_addr;
    logic [127:0] mem_wr_data;

    always #5 clk = ~clk;

    data_cache dut (
        .clk               (clk),
        .rst               (rst),
        .req_valid         (req_valid),
        .req_we            (req_we),
        .req_addr          (req_addr),
        .req_wdata         (req_wdata),
        .req_wstrb         (req_wstrb),
        .data_ok           (data_ok),
        .rdata             (rdata),
        .stall_from_DCache (stall_from_DCache),
        .mem_rd_req        (mem_rd_req),
        .mem_rd_addr       (mem_rd_addr),
        .mem_rd_ready      (mem_rd_ready),
        .mem_rd_valid      (mem_rd_valid),
        .mem_rd_data       (mem_rd_data),
        .mem_wr_req        (mem_wr_req),
        .mem_wr_addr       (mem_wr_addr),
        .mem_wr_data       (mem_wr_data),
        .mem_wr_ready      (mem_wr_ready)
    );

    int n_cmp  = 0;
    int n_fail = 0;

    // Backing memory and the CPU-visible view, both keyed by word address.
    logic [31:0] mem  [int unsigned];
    logic [31:0] gold [int unsigned];
    bit          res_valid [64];
    bit          res_dirty [64];
    logic [21:0] res_tag   [64];

    function automatic logic [31:0] init_word(input int unsigned wa);
        return (wa * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    function automatic logic [31:0] mem_word(input int unsigned wa);
        return mem.exists(wa) ? mem[wa] : init_word(wa);
    endfunction

    function automatic logic [31:0] gold_word(input int unsigned wa);
        return gold.exists(wa) ? gold[wa] : init_word(wa);
    endfunction

    function automatic logic [127:0] mem_line(input logic [31:0] la);
        int unsigned b = 32'(la[31:2]);
        return {mem_word(b + 3), mem_word(b + 2), mem_word(b + 1), mem_word(b)};
    endfunction

    function automatic logic [127:0] gold_line(input logic [31:0] la);
        int unsigned b = 32'(la[31:2]);
        return {gold_word(b + 3), gold_word(b + 2), gold_word(b + 1), gold_word(b)};
    endfunction

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_data_ok"}, 128'(data_ok), 128'(0));
        check({tag, "_stall"}, 128'(stall_from_DCache), 128'(0));
        check({tag, "_rd_req"}, 128'(mem_rd_req), 128'(0));
        check({tag, "_wr_req"}, 128'(mem_wr_req), 128'(0));
        check({tag, "_rdata"}, 128'(rdata), 128'(0));
        check({tag, "_rd_addr"}, 128'(mem_rd_addr), 128'(0));
        check({tag, "_wr_addr"}, 128'(mem_wr_addr), 128'(0));
        check({tag, "_wr_data"}, mem_wr_data, 128'(0));
    endtask

    // Reset discards every cached line, dirty data included.
    task automatic model_reset();
        for (int s = 0; s < 64; s++) begin
            res_valid[s] = 1'b0;
            res_dirty[s] = 1'b0;
        end
        gold = mem;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst       = 1'b1;
        req_valid = 1'b1;
        req_addr  = 32'h0000_0040;
        #1;
        check_zero("reset");
        @(negedge clk);
        rst       = 1'b0;
        req_valid = 1'b0;
        model_reset();
    endtask

    task automatic idle();
        @(negedge clk);
        req_valid    = 1'b0;
        req_addr     = $urandom;
        mem_rd_valid = 1'($urandom_range(0, 1));
        mem_rd_ready = 1'($urandom_range(0, 1));
        mem_wr_ready = 1'($urandom_range(0, 1));
        mem_rd_data  = {$urandom, $urandom, $urandom, $urandom};
        #1;
        check("idle_data_ok", 128'(data_ok), 128'(0));
        check("idle_stall", 128'(stall_from_DCache), 128'(0));
        check("idle_rd_req", 128'(mem_rd_req), 128'(0));
        check("idle_wr_req", 128'(mem_wr_req), 128'(0));
    endtask

    task automatic access(input logic we, input logic [31:0] addr, input logic [31:0] wd,
                          input logic [3:0] ws, input int wr_dly, input int rd_dly,
                          input int rd_lat);
        logic [5:0]  idx;
        logic [21:0] tg;
        int unsigned wa, vb;
        logic [31:0] la, va, g;
        idx = addr[9:4];
        tg  = addr[31:10];
        wa  = 32'(addr[31:2]);
        la  = {addr[31:4], 4'b0};
        @(negedge clk);
        req_valid = 1'b1;
        req_we    = we;
        req_addr  = addr;
        req_wdata = wd;
        req_wstrb = ws;
        #1;
        if (!(res_valid[idx] && res_tag[idx] == tg)) begin
            check("miss_data_ok", 128'(data_ok), 128'(0));
            check("miss_stall", 128'(stall_from_DCache), 128'(1));
            check("miss_rd_req", 128'(mem_rd_req), 128'(0));
            if (res_valid[idx] && res_dirty[idx]) begin
                va = {res_tag[idx], idx, 4'b0};
                for (int d = 0; d <= wr_dly; d++) begin
                    @(negedge clk);
                    mem_wr_ready = (d == wr_dly);
                    #1;
                    check("wb_req", 128'(mem_wr_req), 128'(1));
                    check("wb_addr", 128'(mem_wr_addr), 128'(va));
                    check("wb_data", mem_wr_data, gold_line(va));
                    check("wb_stall", 128'(stall_from_DCache), 128'(1));
                end
                vb = 32'(va[31:2]);
                for (int k = 0; k < 4; k++) mem[vb + k] = gold_word(vb + k);
            end
            for (int d = 0; d <= rd_dly; d++) begin
                @(negedge clk);
                mem_wr_ready = 1'b0;
                mem_rd_ready = (d == rd_dly);
                #1;
                check("rf_req", 128'(mem_rd_req), 128'(1));
                check("rf_addr", 128'(mem_rd_addr), 128'(la));
                check("rf_stall", 128'(stall_from_DCache), 128'(1));
                check("rf_wr_req", 128'(mem_wr_req), 128'(0));
            end
            for (int d = 0; d <= rd_lat; d++) begin
                @(negedge clk);
                mem_rd_ready = 1'b0;
                mem_rd_valid = (d == rd_lat);
                mem_rd_data  = (d == rd_lat) ? mem_line(la)
                                             : {$urandom, $urandom, $urandom, $urandom};
                #1;
                check("wait_rd_req", 128'(mem_rd_req), 128'(0));
                check("wait_stall", 128'(stall_from_DCache), 128'(1));
                check("wait_data_ok", 128'(data_ok), 128'(0));
            end
            res_valid[idx] = 1'b1;
            res_dirty[idx] = 1'b0;
            res_tag[idx]   = tg;
            @(negedge clk);
            mem_rd_valid = 1'b0;
            mem_rd_data  = '0;
            #1;
        end
        check("hit_data_ok", 128'(data_ok), 128'(1));
        check("hit_stall", 128'(stall_from_DCache), 128'(0));
        check("hit_no_rd", 128'(mem_rd_req), 128'(0));
        check("hit_no_wr", 128'(mem_wr_req), 128'(0));
        if (!we) begin
            check("load_rdata", 128'(rdata), 128'(gold_word(wa)));
        end else begin
            g = gold_word(wa);
            for (int b = 0; b < 4; b++) if (ws[b]) g[b*8 +: 8] = wd[b*8 +: 8];
            gold[wa]       = g;
            res_dirty[idx] = 1'b1;
        end
    endtask

    initial begin
        logic [31:0] a;
        rst          = 1'b1;
        req_valid    = 1'b0;
        req_we       = 1'b0;
        req_addr     = '0;
        req_wdata    = '0;
        req_wstrb    = '0;
        mem_rd_ready = 1'b0;
        mem_rd_valid = 1'b0;
        mem_rd_data  = '0;
        mem_wr_ready = 1'b0;
        mem[32'h10]  = 32'h11;
        mem[32'h11]  = 32'h22;
        mem[32'h12]  = 32'h33;
        mem[32'h13]  = 32'h44;

        do_reset();
        idle();

        // Cold miss on 0x40, then word stores and a strobed byte merge.
        access(1'b0, 32'h0000_0040, 32'h0, 4'h0, 0, 0, 2);
        access(1'b1, 32'h0000_0044, 32'h1122_3344, 4'hF, 0, 0, 0);
        access(1'b1, 32'h0000_0044, 32'hAABB_CCDD, 4'b0010, 0, 0, 0);
        access(1'b0, 32'h0000_0044, 32'h0, 4'h0, 0, 0, 0);
        // Conflict on the dirty line forces a writeback of 0x40 before refilling 0x440.
        access(1'b0, 32'h0000_0440, 32'h0, 4'h0, 1, 0, 1);
        access(1'b0, 32'h0000_0044, 32'h0, 4'h0, 0, 0, 0);
        access(1'b0, 32'h0000_0500, 32'h0, 4'h0, 0, 5, 0);

        // Reset while waiting for refill data; the late return must be dropped.
        @(negedge clk);
        req_valid    = 1'b1;
        req_we       = 1'b0;
        req_addr     = 32'h0000_0880;
        mem_rd_ready = 1'b0;
        mem_wr_ready = 1'b0;
        mem_rd_valid = 1'b0;
        #1;
        check("rstw_stall", 128'(stall_from_DCache), 128'(1));
        @(negedge clk);
        mem_rd_ready = 1'b1;
        #1;
        check("rstw_rd_addr", 128'(mem_rd_addr), 128'(32'h0000_0880));
        @(negedge clk);
        mem_rd_ready = 1'b0;
        rst          = 1'b1;
        req_valid    = 1'b0;
        #1;
        check_zero("rstw");
        @(negedge clk);
        rst          = 1'b0;
        mem_rd_valid = 1'b1;
        mem_rd_data  = {4{32'hDEAD_BEEF}};
        model_reset();
        #1;
        check("late_valid_rd_req", 128'(mem_rd_req), 128'(0));
        @(negedge clk);
        mem_rd_valid = 1'b0;
        access(1'b0, 32'h0000_0880, 32'h0, 4'h0, 0, 0, 1);

        // Store miss with a clean victim, then eviction proves the line went dirty.
        access(1'b1, 32'h0000_0084, 32'h1234_5678, 4'b1001, 0, 1, 1);
        access(1'b0, 32'h0000_0084, 32'h0, 4'h0, 0, 0, 0);
        access(1'b0, 32'h0000_0484, 32'h0, 4'h0, 0, 0, 0);

        for (int i = 0; i < 400; i++) begin
            a = {22'($urandom_range(0, 3)), 6'($urandom_range(0, 7)),
                 2'($urandom_range(0, 3)), 2'b00};
            access(1'($urandom_range(0, 1)), a, $urandom, 4'($urandom),
                   $urandom_range(0, 2), $urandom_range(0, 2), $urandom_range(0, 3));
            if ($urandom_range(0, 3) == 0) idle();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/data_cache.md
# data_cache

Direct-mapped, write-back, write-allocate L1 data cache for the MEM stage of the 32-bit LoongArch pipeline. It serves byte-masked loads and stores from the MEM stage. Hits complete in the request cycle. On a miss it raises a stall, which freezes the pipeline registers, runs a dirty-line writeback and/or a line refill against main memory, then completes the held request on replay.

## Interface
Parameters:
- LINE_WORDS, 4, 32-bit words per line (line = 128 bits)
- SETS, 64, number of lines (index width log2(SETS))

Ports:
- clk  in  1  clock (single clock domain)
- rst  in  1  synchronous, active-high reset
- req_valid  in  1  MEM stage holds a load/store
- req_we  in  1  1 = store, 0 = load
- req_addr  in  32  byte address; alignment is already checked upstream
- req_wdata  in  32  store data, lane-aligned
- req_wstrb  in  4  store byte enables
- data_ok  out  1  request completes this cycle
- rdata  out  32  load word, valid when data_ok && !req_we
- stall_from_DCache  out  1  req_valid && !data_ok
- mem_rd_req  out  1  refill request
- mem_rd_addr  out  32  line-aligned refill address
- mem_rd_ready  in  1  memory accepts the refill address
- mem_rd_valid  in  1  refill line returned
- mem_rd_data  in  32*LINE_WORDS  refill line
- mem_wr_req  out  1  writeback request
- mem_wr_addr  out  32  line-aligned victim address
- mem_wr_data  out  32*LINE_WORDS  victim line
- mem_wr_ready  in  1  writeback accepted and complete

## Operation
- Address split for the defaults:
  - byte [1:0]
  - word [3:2]
  - index [9:4]
  - tag [31:10], 22 bits
- Each line holds valid, dirty, tag and data, all in flops. Lookup is combinational.
- hit = valid[index] && tag[index] == addr tag.
- Load hit: rdata = the addressed word; data_ok = 1.
- Store hit: on the clock edge, bytes with req_wstrb set are merged into the addressed word and dirty is set; data_ok = 1.
- FSM states: IDLE, WRITEBACK, REFILL_REQ, REFILL_WAIT.
- IDLE, req_valid and miss:
  - victim valid and dirty: go to WRITEBACK
  - otherwise: go to REFILL_REQ
- WRITEBACK: mem_wr_req = 1, mem_wr_addr = {victim tag, index, 4'b0}, mem_wr_data = victim line. On mem_wr_ready, go to REFILL_REQ.
- REFILL_REQ: mem_rd_req = 1, mem_rd_addr = {req tag, index, 4'b0}. On mem_rd_ready, go to REFILL_WAIT.
- REFILL_WAIT: on mem_rd_valid, install the line with valid = 1, dirty = 0, new tag, then go to IDLE. The request is replayed from IDLE as a hit.
- data_ok is asserted only in IDLE. In every other state, stall_from_DCache = req_valid.
- The request inputs are held stable while stall_from_DCache = 1; the pipeline guarantees this, and the cache does not latch them.
- mem_rd_valid outside REFILL_WAIT is ignored. mem_rd_ready and mem_wr_ready outside their own state are ignored.
- req_valid = 0: no lookup, no state change, data_ok = 0.

## Timing
- Reset, synchronous:
  - all valid and dirty bits = 0; tag and data arrays are not reset
  - FSM = IDLE
  - data_ok, mem_rd_req, mem_wr_req, stall_from_DCache = 0
  - rdata, mem_rd_addr, mem_wr_addr, mem_wr_data = 0
- Reset while a memory request is outstanding abandons it. A late mem_rd_valid is then ignored.
- Hit latency: 0 cycles (same cycle as req_valid).
- Clean miss, memory ready immediately, line returned N cycles after acceptance:
  - cycle 0: detect miss
  - cycle 1: mem_rd_req
  - cycles 2..N+1: wait; install on the cycle mem_rd_valid is seen
  - next cycle: IDLE hit, data_ok
- Dirty miss: same sequence, with at least 1 extra cycle in WRITEBACK before REFILL_REQ.
- mem_*_req stay asserted, and addr/data stay constant, until the matching ready is seen.

## Structure
- Shared package:
  - LINE_WORDS, SETS
  - derived widths: OFFSET_W, INDEX_W, TAG_W
  - FSM state enum
- Sub-module data_cache_array: valid, dirty, tag and data storage.
  - one combinational read port by index
  - one write port: either a full-line install or a byte-masked word write with dirty set

## Test plan
- After reset, load 0x0000_0040 → miss, mem_rd_addr = 0x0000_0040. Return line words {0x44,0x33,0x22,0x11} (word0 = 0x11) → replay rdata = 0x11, data_ok = 1.
- Store 0xAABBCCDD, wstrb = 4'b0010, to a cached word holding 0x11223344. A following load returns 0x1122CC44, the line is dirty, and there is no memory traffic.
- Load 0x0000_0440 (same index, different tag) on that dirty line → mem_wr_addr = 0x0000_0040 with the modified line, then mem_rd_addr = 0x0000_0440, then hit.
- Hold mem_rd_ready = 0 for 5 cycles → mem_rd_req and mem_rd_addr stay stable, stall_from_DCache = 1 throughout.
- Assert rst during REFILL_WAIT, then pulse mem_rd_valid → ignored; a subsequent load to the same address misses.
- Store miss to 0x0000_0084, clean victim → refill, then the word is written and dirty is set; the refill content merges with the store bytes.
